// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums ACC_LEN signed beats from the MAC array, applies
// optional ReLU, and queues completed sums in a show-ahead output FIFO.
module psum_accumulator #(
  parameter int bw_psum    = 22,
  parameter int bw_acc     = 26,
  parameter int ACC_LEN    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RELU_EN    = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [bw_psum-1:0] in_psum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [bw_acc-1:0]  out_data,
  output logic                      busy
);

  localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  function automatic logic signed [bw_acc-1:0] relu(input logic signed [bw_acc-1:0] x);
    if ((RELU_EN != 0) && x[bw_acc-1]) return '0;
    return x;
  endfunction

  logic        [CW-1:0]     cnt;
  logic signed [bw_acc-1:0] acc;
  logic signed [bw_acc-1:0] mem [FIFO_DEPTH];
  logic        [PW-1:0]     wr_ptr;
  logic        [PW-1:0]     rd_ptr;
  logic        [PW:0]       count;

  logic signed [bw_acc-1:0] psum_ext_p0;
  logic signed [bw_acc-1:0] sum_p0;
  logic                     accept;
  logic                     last_beat;
  logic                     push;
  logic                     pop;

  // Stage p0: sign-extend the incoming beat and form the running sum
  assign psum_ext_p0 = {{(bw_acc-bw_psum){in_psum[bw_psum-1]}}, in_psum};
  assign sum_p0      = (cnt == '0) ? psum_ext_p0 : acc + psum_ext_p0;

  assign in_ready  = (count != (PW+1)'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == CW'(ACC_LEN-1));
  // A flushed final beat is dropped, so it must not reach the FIFO
  assign push      = accept && last_beat && !flush;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign busy      = (cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (flush) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      acc <= sum_p0;
      cnt <= last_beat ? '0 : cnt + CW'(1);
    end
  end

  // Stage p1: completed sums enter the output FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= relu(sum_p0);
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: table of whole-group vectors plus
// hand sequences for backpressure, push/pop overlap, flush and async reset.
module tb_psum_accumulator;

  logic clk = 0;
  logic reset_n = 0;
  logic flush = 0;
  logic in_valid = 0;
  logic out_ready = 0;
  logic signed [21:0] in_psum = '0;
  logic in_ready, out_valid, busy;
  logic signed [25:0] out_data;
  logic in_ready_r, out_valid_r, busy_r;
  logic signed [25:0] out_data_r;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  psum_accumulator #(.RELU_EN(0)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_psum(in_psum), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy));

  psum_accumulator #(.RELU_EN(1)) dut_r (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready_r), .in_psum(in_psum), .out_valid(out_valid_r),
    .out_ready(out_ready), .out_data(out_data_r), .busy(busy_r));

  typedef struct {
    logic signed [21:0] beat;
    longint             exp_plain;
    longint             exp_relu;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the beat until it is accepted; flush is applied on the accepting edge only
  task automatic send_beat(input logic signed [21:0] v, input logic fl);
    bit done;
    done = 0;
    in_valid = 1;
    in_psum  = v;
    flush    = fl;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1;
      step();
    end
    flush = 0;
    if (!done) check("beat_timeout", 0, 1);
  endtask

  task automatic send_group(input logic signed [21:0] first, input logic signed [21:0] rest);
    send_beat(first, 0);
    for (int b = 1; b < 8; b++) send_beat(rest, 0);
    in_valid = 0;
  endtask

  initial begin
    vecs[0] = '{beat: 22'sd100,      exp_plain: 800,       exp_relu: 800};
    vecs[1] = '{beat: -22'sd2097152, exp_plain: -16777216, exp_relu: 0};
    vecs[2] = '{beat: 22'sd2097151,  exp_plain: 16777208,  exp_relu: 16777208};
    vecs[3] = '{beat: -22'sd5,       exp_plain: -40,       exp_relu: 0};
    vecs[4] = '{beat: 22'sd0,        exp_plain: 0,         exp_relu: 0};
    vecs[5] = '{beat: 22'sd3,        exp_plain: 24,        exp_relu: 24};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    reset_n = 1;
    #1;
    check("rst_in_ready", in_ready, 1);
    step();

    // Table-driven groups, consumer always ready
    out_ready = 1;
    foreach (vecs[v]) begin
      for (int b = 0; b < 7; b++) begin
        send_beat(vecs[v].beat, 0);
        check($sformatf("v%0d_busy_b%0d", v, b + 1), busy, 1);
      end
      check($sformatf("v%0d_no_early_out", v), out_valid, 0);
      send_beat(vecs[v].beat, 0);
      in_valid = 0;
      check($sformatf("v%0d_out_valid", v), out_valid, 1);
      check($sformatf("v%0d_out_data", v), out_data, vecs[v].exp_plain);
      check($sformatf("v%0d_relu_data", v), out_data_r, vecs[v].exp_relu);
      check($sformatf("v%0d_busy_end", v), busy, 0);
      step();
      check($sformatf("v%0d_popped", v), out_valid, 0);
    end

    // Backpressure: four groups fill the FIFO, fifth stalls on its first beat
    out_ready = 0;
    for (int k = 1; k <= 4; k++) send_group(22'(k), 22'sd0);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_head", out_data, 1);
    in_valid = 1;
    in_psum  = 22'sd5;
    repeat (3) step();
    check("bp_stall_in_ready", in_ready, 0);
    check("bp_stall_busy", busy, 0);
    out_ready = 1;
    step();
    check("bp_after_pop_head", out_data, 2);
    check("bp_after_pop_ready", in_ready, 1);
    check("bp_after_pop_busy", busy, 0);
    out_ready = 0;
    step();
    check("bp_first_beat_taken", busy, 1);
    for (int b = 1; b < 8; b++) send_beat(22'sd0, 0);
    in_valid = 0;
    out_ready = 1;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("bp_drain_%0d", k), out_data, k);
      step();
    end
    check("bp_drained", out_valid, 0);

    // Simultaneous push and pop with three entries queued
    out_ready = 0;
    send_group(22'sd10, 22'sd0);
    send_group(22'sd20, 22'sd0);
    send_group(22'sd30, 22'sd0);
    send_beat(22'sd40, 0);
    for (int b = 1; b < 7; b++) send_beat(22'sd1, 0);
    out_ready = 1;
    send_beat(22'sd1, 0);
    in_valid = 0;
    check("pp_head", out_data, 20);
    check("pp_in_ready", in_ready, 1);
    step();
    check("pp_second", out_data, 30);
    step();
    check("pp_tail", out_data, 47);
    step();
    check("pp_empty", out_valid, 0);

    // Flush with beat 6 of a group; a pre-queued entry survives
    out_ready = 0;
    send_group(22'sd7, 22'sd0);
    for (int b = 0; b < 5; b++) send_beat(22'sd10, 0);
    send_beat(22'sd10, 1);
    in_valid = 0;
    check("fl_busy", busy, 0);
    check("fl_head_kept", out_data, 7);
    send_group(22'sd1, 22'sd1);
    out_ready = 1;
    check("fl_drain_old", out_data, 7);
    step();
    check("fl_drain_new", out_data, 8);
    step();
    check("fl_empty", out_valid, 0);

    // Async reset mid-group with two FIFO entries
    out_ready = 0;
    send_group(22'sd1, 22'sd0);
    send_group(22'sd2, 22'sd0);
    for (int b = 0; b < 3; b++) send_beat(22'sd9, 0);
    in_valid = 0;
    check("ar_busy_before", busy, 1);
    #2;
    reset_n = 0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_out_data", out_data, 0);
    check("ar_busy", busy, 0);
    step();
    #2;
    reset_n = 1;
    step();
    check("ar_in_ready", in_ready, 1);
    out_ready = 1;
    send_group(22'sd3, 22'sd3);
    check("ar_fresh_valid", out_valid, 1);
    check("ar_fresh_data", out_data, 24);
    step();
    check("ar_fresh_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the 8-lane signed MAC array.
- Accepts one signed partial sum per cycle over a valid/ready handshake and accumulates ACC_LEN consecutive partial sums into one output.
- Applies an optional ReLU to each completed sum and buffers results in a small show-ahead output FIFO for the consumer (output SRAM writer).

Parameters:
- bw_psum, 22, width of incoming signed partial sum (matches MAC output width)
- bw_acc, 26, accumulator and output width (bw_psum+4; covers ACC_LEN up to 16 with no overflow)
- ACC_LEN, 8, partial sums per output; legal range 1..16
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2
- RELU_EN, 0, 1 = clamp negative completed sums to 0

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of the current partial group
- in_valid  in  1  in_psum is valid
- in_ready  out  1  block can accept a beat
- in_psum  in  bw_psum  signed (two's complement) partial sum
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer takes the FIFO head
- out_data  out  bw_acc  signed completed sum at the FIFO head
- busy  out  1  partial group in progress (beat count != 0)

Behaviour:
- Reset (reset_n=0, async): acc=0, beat count=0, FIFO pointers and count=0, all FIFO storage=0. Resulting outputs: out_valid=0, out_data=0, busy=0, in_ready=1 once reset_n=1. A partial group in progress is discarded.
- Accept: a beat is accepted when in_valid && in_ready at a rising edge.
- Ready rule: in_ready = !fifo_full, applied to every beat (not only final beats). in_ready is combinational on FIFO count only; it does not depend on in_valid.
- Sign extension: in_psum is sign-extended to bw_acc before any add.
- Accumulation, beat count c:
  - c==0 on accept: acc <= sext(in_psum).
  - otherwise: acc <= acc + sext(in_psum).
  - c increments on each accepted beat.
- Final beat (c==ACC_LEN-1) on accept:
  - result = (c==0 ? sext(in_psum) : acc + sext(in_psum)).
  - If RELU_EN and result < 0, result = 0.
  - Push result into the FIFO on the same edge; c <= 0.
  - ACC_LEN=1: every accepted beat is a final beat.
- Latency: final beat accepted at edge N, then out_valid=1 and out_data=result in the cycle after edge N.
- Output FIFO:
  - Show-ahead: out_data always shows the head entry; it is 0 and don't-care when out_valid=0.
  - Pop when out_valid && out_ready.
  - Push and pop on the same edge: count unchanged, order preserved.
  - Full: no push can occur, because in_ready=0.
  - Empty: out_ready is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Flush:
  - flush=1 at an edge sets c <= 0 and acc <= 0.
  - A beat accepted on the same edge is dropped, including a final beat (no push).
  - FIFO contents are unaffected; a pop on the same edge still occurs.
- busy = (c != 0), registered.
- No overflow detection: bw_acc is sized so none is possible within the legal ACC_LEN range.

Test Plan:
- Basic: defaults, out_ready=1, eight beats of +100 back-to-back → one output 800, out_valid high exactly one cycle after the 8th accept; busy high from beat 1 through beat 7.
- Sign/extremes: eight beats of -2097152 (min 22-bit) → -16777216 with RELU_EN=0; rerun with RELU_EN=1 → 0. Eight beats of +2097151 → 16777208.
- Backpressure: out_ready=0, stream 5 groups with group k summing to k → after 4 outputs in_ready=0 and the 5th group stalls at its first beat (no beat lost). Raise out_ready → outputs 1,2,3,4,5 in order; in_ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop: FIFO holding 3 entries, final beat accepted on the same edge as a pop → count stays 3, new result lands at the tail.
- Flush: after 5 of 8 beats of +10, assert flush together with beat 6 → no output; the next 8 beats of +1 produce 8. FIFO entries queued before the flush drain unchanged.
- Reset mid-operation: deassert reset_n asynchronously (between edges) mid-group with 2 FIFO entries → out_valid, out_data and busy go to 0 immediately. After release, a fresh 8-beat group of +3 yields 24.
